matrix_mult_seq_ctrl: RTL and testbench

- Sequencing controller plus single shared MAC.
- Computes C = A x B for square unsigned matrices of runtime size N (1..MAX_SIZE) held in external synchronous RAMs.
- Walks i/j/k, issues A/B read addresses, accumulates, and writes each C element back.
- Low-area alternative to the fully parallel multiplier: same row-major element layout, same modulo-2^DATA_WIDTH arithmetic.

---
 rtl/matrix_mult_pkg.sv | 23 ++
 rtl/matrix_mac.sv | 44 ++++
 rtl/matrix_mult_seq_ctrl.sv | 134 +++++++++++++
 tb/tb_matrix_mult_seq_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_mult_pkg.sv
// Shared types and helpers for the matrix multiply datapaths.
//   state_t     : sequencing controller states
//   *_DEFAULT   : default matrix dimension and element width
//   idx()       : row-major flattening, row * max_size + col
package matrix_mult_pkg;

    localparam int unsigned MAX_SIZE_DEFAULT   = 10;
    localparam int unsigned DATA_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWrite,
        StDone
    } state_t;

    // Same flattening the parallel multiplier uses for its element arrays.
    function automatic int unsigned idx(input int unsigned row, input int unsigned col,
                                        input int unsigned max_size);
        return row * max_size + col;
    endfunction

endpackage

// File: rtl/matrix_mac.sv
// Single shared multiply-accumulate unit.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : zero the accumulator
//   en       : accumulate a*b into the accumulator
//   first    : when accumulating, start from zero instead of the held value
//   a, b     : operands (unsigned)
//   sum      : combinational acc + a*b, truncated to DATA_WIDTH
module matrix_mac #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  en,
    input  logic                  first,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum
);

    logic [DATA_WIDTH-1:0] acc_q, acc_d, prod;

    // Context width is DATA_WIDTH, so the product wraps silently.
    assign prod = a * b;
    assign sum  = acc_q + prod;

    always_comb begin
        acc_d = acc_q;
        if (clr) begin
            acc_d = '0;
        end else if (en) begin
            acc_d = (first ? '0 : acc_q) + prod;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/matrix_mult_seq_ctrl.sv
// Sequential matrix multiply controller: C = A x B for N x N unsigned matrices
// (N = 1..MAX_SIZE) stored row-major with stride MAX_SIZE in external sync RAMs.
//   start, matrix_size      : request and size N (captured on accept)
//   busy, done, err         : status; done/err are one-cycle pulses
//   a_addr/a_rdata, b_...   : A/B read ports, data one cycle after address
//   c_we, c_addr, c_wdata   : C write port
module matrix_mult_seq_ctrl
    import matrix_mult_pkg::*;
#(
    parameter int unsigned MAX_SIZE   = MAX_SIZE_DEFAULT,
    parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEFAULT,
    parameter int unsigned ADDR_WIDTH = $clog2(MAX_SIZE * MAX_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [31:0]           matrix_size,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [ADDR_WIDTH-1:0] b_addr,
    input  logic [DATA_WIDTH-1:0] a_rdata,
    input  logic [DATA_WIDTH-1:0] b_rdata,
    output logic                  c_we,
    output logic [ADDR_WIDTH-1:0] c_addr,
    output logic [DATA_WIDTH-1:0] c_wdata
);

    localparam int unsigned CW = $clog2(MAX_SIZE + 1);

    state_t                state_q, state_d;
    logic [CW-1:0]         n_q, i_q, j_q, k_q;
    logic [ADDR_WIDTH-1:0] a_hold_q, b_hold_q;
    logic                  err_q;
    logic                  size_ok, accept, last_k, last_j, last_elem;
    logic [ADDR_WIDTH-1:0] a_idx, b_idx, c_idx;
    logic [DATA_WIDTH-1:0] mac_sum;

    assign size_ok   = (matrix_size != '0) && (matrix_size <= MAX_SIZE);
    assign accept    = (state_q == StIdle) && start && size_ok;
    assign last_k    = (k_q == n_q - CW'(1));
    assign last_j    = (j_q == n_q - CW'(1));
    assign last_elem = last_j && (i_q == n_q - CW'(1));

    assign a_idx = ADDR_WIDTH'(idx(32'(i_q), 32'(k_q), MAX_SIZE));
    assign b_idx = ADDR_WIDTH'(idx(32'(k_q), 32'(j_q), MAX_SIZE));
    assign c_idx = ADDR_WIDTH'(idx(32'(i_q), 32'(j_q), MAX_SIZE));

    // Read data in RUN belongs to k-1, so accumulation starts on k==1 and the
    // k=N-1 product is folded in combinationally during WRITE. Clearing in
    // WRITE/IDLE keeps N==1 (no accumulate cycles) starting from zero.
    matrix_mac #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_mac (
        .clk   (clk),
        .rst   (rst),
        .clr   ((state_q == StWrite) || (state_q == StIdle)),
        .en    ((state_q == StRun) && (k_q != '0)),
        .first (k_q == CW'(1)),
        .a     (a_rdata),
        .b     (b_rdata),
        .sum   (mac_sum)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StRun;
            StRun:   if (last_k) state_d = StWrite;
            StWrite: state_d = last_elem ? StDone : StRun;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs
    always_comb begin
        busy    = (state_q == StRun) || (state_q == StWrite);
        done    = (state_q == StDone);
        err     = err_q;
        c_we    = (state_q == StWrite);
        c_addr  = c_we ? c_idx : '0;
        c_wdata = c_we ? mac_sum : '0;
        // Outside RUN the read addresses hold whatever was last issued.
        a_addr  = (state_q == StRun) ? a_idx : a_hold_q;
        b_addr  = (state_q == StRun) ? b_idx : b_hold_q;
    end

    // Loop counters, captured size, address hold and err pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q      <= '0;
            i_q      <= '0;
            j_q      <= '0;
            k_q      <= '0;
            a_hold_q <= '0;
            b_hold_q <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= (state_q == StIdle) && start && !size_ok;
            if (accept) begin
                n_q <= matrix_size[CW-1:0];
                i_q <= '0;
                j_q <= '0;
                k_q <= '0;
            end
            if (state_q == StRun) begin
                a_hold_q <= a_idx;
                b_hold_q <= b_idx;
                k_q      <= last_k ? '0 : k_q + CW'(1);
            end
            if ((state_q == StWrite) && !last_elem) begin
                if (last_j) begin
                    j_q <= '0;
                    i_q <= i_q + CW'(1);
                end else begin
                    j_q <= j_q + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_matrix_mult_seq_ctrl.sv
// Scoreboard bench for matrix_mult_seq_ctrl: expected C writes, done and err
// pulses are queued with their cycle numbers; a monitor pops and compares.
module tb_matrix_mult_seq_ctrl;

    localparam int MS = 10;
    localparam int DW = 32;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   matrix_size;
    logic          busy, done, err, c_we;
    logic [AW-1:0] a_addr, b_addr, c_addr;
    logic [DW-1:0] a_rdata, b_rdata, c_wdata;

    logic [DW-1:0] mem_a [0:127];
    logic [DW-1:0] mem_b [0:127];

    int cyc = 0;
    int total = 0;
    int bad = 0;
    int done_cnt = 0;
    int n_cur = 1;

    typedef struct {
        int          addr;
        logic [31:0] data;
        int          cyc;
    } wr_t;

    wr_t exp_q[$];
    int  done_q[$];
    int  err_q[$];

    matrix_mult_seq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .matrix_size (matrix_size),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .a_addr      (a_addr),
        .b_addr      (b_addr),
        .a_rdata     (a_rdata),
        .b_rdata     (b_rdata),
        .c_we        (c_we),
        .c_addr      (c_addr),
        .c_wdata     (c_wdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous read RAMs: data one cycle after address.
    always @(posedge clk) begin
        a_rdata <= mem_a[a_addr];
        b_rdata <= mem_b[b_addr];
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic monitor();
        wr_t e;
        int  ec;
        int  lim;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (c_we) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        bad++;
                        $display("FAIL c_we_unexpected: got addr=%0d data=%h required no write",
                                 c_addr, c_wdata);
                    end else begin
                        e = exp_q.pop_front();
                        if (int'(c_addr) != e.addr || c_wdata !== e.data || cyc != e.cyc) begin
                            bad++;
                            $display("FAIL c_write: got addr=%0d data=%h cyc=%0d required %0d %h %0d",
                                     c_addr, c_wdata, cyc, e.addr, e.data, e.cyc);
                        end
                    end
                end
                if (done) begin
                    total++;
                    done_cnt++;
                    if (done_q.size() == 0) begin
                        bad++;
                        $display("FAIL done_unexpected: got done at %0d required none", cyc);
                    end else begin
                        ec = done_q.pop_front();
                        if (cyc != ec) begin
                            bad++;
                            $display("FAIL done_cycle: got %0d required %0d", cyc, ec);
                        end
                    end
                end
                if (err) begin
                    total++;
                    if (err_q.size() == 0) begin
                        bad++;
                        $display("FAIL err_unexpected: got err at %0d required none", cyc);
                    end else begin
                        ec = err_q.pop_front();
                        if (cyc != ec) begin
                            bad++;
                            $display("FAIL err_cycle: got %0d required %0d", cyc, ec);
                        end
                    end
                end
                if (busy) begin
                    lim = (n_cur - 1) * MS + (n_cur - 1);
                    total++;
                    if (int'(a_addr) > lim || int'(b_addr) > lim) begin
                        bad++;
                        $display("FAIL rd_addr_range: got a=%0d b=%0d required <= %0d",
                                 a_addr, b_addr, lim);
                    end
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Reference: C[i][j] = sum_k A[i][k]*B[k][j], taken modulo 2^32.
    task automatic push_expected(input int n, input int t0);
        logic [63:0] s;
        wr_t         e;
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < n; j++) begin
                s = '0;
                for (int k = 0; k < n; k++) begin
                    s = s + 64'(mem_a[i * MS + k]) * 64'(mem_b[k * MS + j]);
                end
                e.addr = i * MS + j;
                e.data = s[31:0];
                e.cyc  = t0 + (i * n + j + 1) * (n + 1);
                exp_q.push_back(e);
            end
        end
        done_q.push_back(t0 + n * n * (n + 1) + 1);
    endtask

    task automatic fill_random();
        for (int a = 0; a < 128; a++) begin
            mem_a[a] = $urandom;
            mem_b[a] = $urandom;
        end
    endtask

    task automatic kick(input int n);
        step();
        n_cur       = n;
        start       = 1'b1;
        matrix_size = n;
        push_expected(n, cyc);
        step();
        start       = 1'b0;
        matrix_size = $urandom;
        chk("busy_after_accept", {31'b0, busy}, 32'd1);
    endtask

    task automatic run_case(input int n, input bit poke);
        int base;
        int lim;
        int c;
        base = done_cnt;
        kick(n);
        lim = n * n * (n + 1) + 10;
        c = 0;
        while (done_cnt == base && c < lim) begin
            if (poke && (c % 5 == 2)) begin
                start       = 1'b1;
                matrix_size = $urandom_range(1, MS);
            end else begin
                start = 1'b0;
            end
            step();
            c++;
        end
        start = 1'b0;
        chk("done_seen", done_cnt - base, 32'd1);
        step();
        chk("busy_after_done", {31'b0, busy}, 32'd0);
    endtask

    task automatic bad_size(input logic [31:0] sz);
        step();
        start       = 1'b1;
        matrix_size = sz;
        err_q.push_back(cyc + 1);
        step();
        start = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chk("busy_on_bad_size", {31'b0, busy}, 32'd0);
            step();
        end
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
        chk({tag, "_done"}, {31'b0, done}, 32'd0);
        chk({tag, "_err"}, {31'b0, err}, 32'd0);
        chk({tag, "_c_we"}, {31'b0, c_we}, 32'd0);
        chk({tag, "_a_addr"}, 32'(a_addr), 32'd0);
        chk({tag, "_b_addr"}, 32'(b_addr), 32'd0);
        chk({tag, "_c_addr"}, 32'(c_addr), 32'd0);
        chk({tag, "_c_wdata"}, c_wdata, 32'd0);
    endtask

    initial begin
        int c;
        rst         = 1'b1;
        start       = 1'b0;
        matrix_size = '0;
        for (int a = 0; a < 128; a++) begin
            mem_a[a] = '0;
            mem_b[a] = '0;
        end
        fork
            monitor();
        join_none
        #1;
        chk_outputs_zero("reset");
        step();
        step();
        rst = 1'b0;

        // 2x2 worked example: 19, 22, 43, 50
        mem_a[0] = 1;  mem_a[1] = 2;  mem_a[10] = 3; mem_a[11] = 4;
        mem_b[0] = 5;  mem_b[1] = 6;  mem_b[10] = 7; mem_b[11] = 8;
        run_case(2, 1'b0);

        // 1x1
        mem_a[0] = 7;
        mem_b[0] = 6;
        run_case(1, 1'b0);

        // Rejected sizes
        bad_size(32'd0);
        bad_size(32'd11);
        bad_size(32'hFFFF_FFFF);

        // Identity times random at full size
        fill_random();
        for (int i = 0; i < MS; i++) begin
            for (int j = 0; j < MS; j++) begin
                mem_a[i * MS + j] = (i == j) ? 32'd1 : 32'd0;
            end
        end
        run_case(MS, 1'b0);

        // Wrap-around
        for (int a = 0; a < 128; a++) begin
            mem_a[a] = 32'hFFFF_FFFF;
            mem_b[a] = 32'hFFFF_FFFF;
        end
        run_case(2, 1'b0);

        // Random sizes with start poked while busy
        for (int r = 0; r < 3; r++) begin
            fill_random();
            run_case(int'($urandom_range(1, MS)), 1'b1);
        end

        // Reset in the middle of a write
        fill_random();
        kick(MS);
        c = 0;
        while (exp_q.size() > 97 && c < 400) begin
            step();
            c++;
        end
        chk("c_we_before_reset", {31'b0, c_we}, 32'd1);
        rst = 1'b1;
        #1;
        chk_outputs_zero("async_reset");
        exp_q.delete();
        done_q.delete();
        step();
        step();
        rst = 1'b0;
        fill_random();
        run_case(3, 1'b0);

        step();
        step();
        chk("writes_left", exp_q.size(), 32'd0);
        chk("dones_left", done_q.size(), 32'd0);
        chk("errs_left", err_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
